// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter and sequencer for a single-port RAM.
// Define RAM_ARB_CLEAR_EN to zero-fill the RAM after reset before accepting traffic.
module ram_arbiter #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          busy,
    output logic          ram_wr_en,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } state_t;

`ifdef RAM_ARB_CLEAR_EN
    localparam state_t RST_STATE = ST_CLEAR;
`else
    localparam state_t RST_STATE = ST_ARB;
`endif

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic          gnt0_d, gnt1_d;
    logic          wr_en_d, busy_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] din_d;
    logic          rd_vld_d, rd_id_d;
    logic          s1_vld_q, s1_id_q;
    logic          s2_vld_q, s2_id_q;
    logic          m0, m1;
`ifdef RAM_ARB_CLEAR_EN
    logic [AW-1:0] cnt_q, cnt_d;
`endif

    // A requester granted last cycle is not eligible on this edge
    assign m0 = req0 & ~gnt0;
    assign m1 = req1 & ~gnt1;

    // Next state, arbitration and next RAM-port values
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        wr_en_d  = 1'b0;
        busy_d   = 1'b0;
        addr_d   = ram_addr;
        din_d    = '0;
        rd_vld_d = 1'b0;
        rd_id_d  = 1'b0;
`ifdef RAM_ARB_CLEAR_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            ST_CLEAR: begin
`ifdef RAM_ARB_CLEAR_EN
                wr_en_d = 1'b1;
                busy_d  = 1'b1;
                addr_d  = cnt_q;
                cnt_d   = cnt_q + AW'(1);
                if (cnt_q == '1) begin
                    state_d = ST_ARB;
                end
`else
                state_d = ST_ARB;
`endif
            end
            ST_ARB: begin
                // Requester 0 wins when alone, or on contention if 1 won last
                if (m0 && (!m1 || last_q)) begin
                    gnt0_d   = 1'b1;
                    last_d   = 1'b0;
                    addr_d   = addr0;
                    wr_en_d  = we0;
                    din_d    = we0 ? wdata0 : '0;
                    rd_vld_d = ~we0;
                    rd_id_d  = 1'b0;
                end else if (m1) begin
                    gnt1_d   = 1'b1;
                    last_d   = 1'b1;
                    addr_d   = addr1;
                    wr_en_d  = we1;
                    din_d    = we1 ? wdata1 : '0;
                    rd_vld_d = ~we1;
                    rd_id_d  = 1'b1;
                end
            end
        endcase
    end

    // State, pointer and registered RAM-port / grant outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= RST_STATE;
            last_q    <= 1'b1;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            busy      <= 1'b0;
            ram_wr_en <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
`ifdef RAM_ARB_CLEAR_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt0      <= gnt0_d;
            gnt1      <= gnt1_d;
            busy      <= busy_d;
            ram_wr_en <= wr_en_d;
            ram_addr  <= addr_d;
            ram_din   <= din_d;
`ifdef RAM_ARB_CLEAR_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // Read tag pipeline: returns RAM data to the issuing requester two cycles after grant
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_vld_q <= 1'b0;
            s1_id_q  <= 1'b0;
            s2_vld_q <= 1'b0;
            s2_id_q  <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            s1_vld_q <= rd_vld_d;
            s1_id_q  <= rd_id_d;
            s2_vld_q <= s1_vld_q;
            s2_id_q  <= s1_id_q;
            rvalid0  <= s2_vld_q & ~s2_id_q;
            rvalid1  <= s2_vld_q & s2_id_q;
            if (s2_vld_q && !s2_id_q) begin
                rdata0 <= ram_dout;
            end
            if (s2_vld_q && s2_id_q) begin
                rdata1 <= ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random traffic for ram_arbiter against a transaction-level model.
// Honours RAM_ARB_CLEAR_EN the same way the design does.
`timescale 1ns/1ps
module tb_ram_arbiter;
    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, busy, ram_wr_en;
    logic [DW-1:0] rdata0, rdata1, ram_din, ram_dout;
    logic [AW-1:0] ram_addr;

    int checks   = 0;
    int failures = 0;

    ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] init_val(input int a);
        return DW'(a * 37 + 11);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Single-port RAM with 1-cycle registered read
    logic [DW-1:0] mem [DEPTH];
    initial begin
        logic [DW-1:0] rd_tmp;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = init_val(i);
        ram_dout = '0;
        forever begin
            @(posedge clk);
            rd_tmp = mem[ram_addr];
            if (ram_wr_en) mem[ram_addr] = ram_din;
            ram_dout <= rd_tmp;
        end
    end

    // Reference model: shadow memory updated in grant order, reads due two cycles later
    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rd_t;

    logic [DW-1:0] shadow [DEPTH];
    rd_t           pend [$];
    logic          e_g0, e_g1, e_wr, e_busy, e_rv0, e_rv1;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din, e_rd0, e_rd1;
    int            cyc, last, clr_left;

    task automatic model_reset();
        e_g0 = 0; e_g1 = 0; e_wr = 0; e_busy = 0; e_rv0 = 0; e_rv1 = 0;
        e_addr = '0; e_din = '0; e_rd0 = '0; e_rd1 = '0;
        last = 1; cyc = 0;
        pend.delete();
`ifdef RAM_ARB_CLEAR_EN
        clr_left = int'(DEPTH);
`else
        clr_left = 0;
`endif
    endtask

    task automatic model_step();
        int            win;
        logic          r0, r1, w_we;
        logic [AW-1:0] w_a;
        logic [DW-1:0] w_d;
        cyc++;
        e_rv0 = 0;
        e_rv1 = 0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            if (pend[0].id == 0) begin e_rv0 = 1; e_rd0 = pend[0].data; end
            else                 begin e_rv1 = 1; e_rd1 = pend[0].data; end
            void'(pend.pop_front());
        end
        if (clr_left > 0) begin
            e_busy = 1; e_g0 = 0; e_g1 = 0; e_wr = 1; e_din = '0;
            e_addr = AW'(int'(DEPTH) - clr_left);
            shadow[e_addr] = '0;
            clr_left--;
        end else begin
            e_busy = 0;
            r0 = req0 && !e_g0;
            r1 = req1 && !e_g1;
            win = -1;
            if (r0 && r1) win = (last == 1) ? 0 : 1;
            else if (r0)  win = 0;
            else if (r1)  win = 1;
            e_g0 = (win == 0);
            e_g1 = (win == 1);
            if (win < 0) begin
                e_wr = 0; e_din = '0;
            end else begin
                w_we = (win == 0) ? we0 : we1;
                w_a  = (win == 0) ? addr0 : addr1;
                w_d  = (win == 0) ? wdata0 : wdata1;
                e_addr = w_a;
                e_wr   = w_we;
                e_din  = w_we ? w_d : '0;
                last   = win;
                if (w_we) shadow[w_a] = w_d;
                else      pend.push_back('{cyc + 2, win, shadow[w_a]});
            end
        end
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) shadow[i] = init_val(i);
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Every-cycle compare of DUT outputs against the model
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                chk("gnt0", 32'(gnt0), 32'(e_g0));
                chk("gnt1", 32'(gnt1), 32'(e_g1));
                chk("busy", 32'(busy), 32'(e_busy));
                chk("ram_wr_en", 32'(ram_wr_en), 32'(e_wr));
                chk("ram_addr", 32'(ram_addr), 32'(e_addr));
                chk("ram_din", 32'(ram_din), 32'(e_din));
                chk("rvalid0", 32'(rvalid0), 32'(e_rv0));
                chk("rvalid1", 32'(rvalid1), 32'(e_rv1));
                chk("rdata0", 32'(rdata0), 32'(e_rd0));
                chk("rdata1", 32'(rdata1), 32'(e_rd1));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'({gnt0, gnt1}), 32'd0);
        chk({tag, "_rvalid"}, 32'({rvalid0, rvalid1}), 32'd0);
        chk({tag, "_rdata0"}, 32'(rdata0), 32'd0);
        chk({tag, "_rdata1"}, 32'(rdata1), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ram_ctl"}, 32'({ram_wr_en, ram_addr, ram_din}), 32'd0);
    endtask

    // One access on master id; caller is at a negedge. Returns cycles to grant and to rvalid.
    task automatic do_access(input int id, input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, output int gwait, output int rwait,
                             output logic [DW-1:0] rd, output int other_rv);
        logic got;
        if (id == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
        else         begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
        gwait = 0; rwait = 0; rd = '0; other_rv = 0; got = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            gwait++;
            if ((id == 0) ? gnt0 : gnt1) begin got = 1; break; end
        end
        if (id == 0) req0 = 0; else req1 = 0;
        chk("grant_seen", 32'(got), 32'd1);
        if (got && !we) begin
            got = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                rwait++;
                if ((id == 0) ? rvalid1 : rvalid0) other_rv++;
                if ((id == 0) ? rvalid0 : rvalid1) begin
                    rd = (id == 0) ? rdata0 : rdata1;
                    got = 1;
                    break;
                end
            end
            chk("rvalid_seen", 32'(got), 32'd1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1ms;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int            gw, rw, orv, gw1, rw1, orv1, n, pulses, consec, rvcount;
        logic          prev;
        logic [DW-1:0] rd, rd1;
        rst_n = 0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1;

        // Post-reset: read 0x55 (held through the clear sequence if present)
`ifdef RAM_ARB_CLEAR_EN
        n = 0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    @(negedge clk);
                    if (!busy) break;
                    n++;
                end
            end
            do_access(0, 1'b0, 8'h55, 8'h00, gw, rw, rd, orv);
        join
        chk("clear_len", 32'(n), 32'd256);
        chk("first_gnt_cycle", 32'(gw), 32'd257);
        chk("clear_rdata", 32'(rd), 32'h00);
`else
        do_access(0, 1'b0, 8'h55, 8'h00, gw, rw, rd, orv);
        chk("first_gnt_cycle", 32'(gw), 32'd1);
        chk("init_rdata", 32'(rd), 32'(init_val(8'h55)));
`endif
        idle(2);

        // Same-address race: pointer set to 1 by a lone requester-1 write, then contention
        do_access(1, 1'b1, 8'h20, 8'h77, gw, rw, rd, orv);
        idle(2);
        fork
            do_access(0, 1'b0, 8'h20, 8'h00, gw, rw, rd, orv);
            do_access(1, 1'b1, 8'h20, 8'h3C, gw1, rw1, rd1, orv1);
        join
        chk("race_gnt0_first", 32'(gw), 32'd1);
        chk("race_gnt1_second", 32'(gw1), 32'd2);
        chk("race_old", 32'(rd), 32'h77);
        idle(2);
        do_access(0, 1'b0, 8'h20, 8'h00, gw, rw, rd, orv);
        chk("race_new", 32'(rd), 32'h3C);
        idle(2);

        // Single requester write then read
        do_access(0, 1'b1, 8'h10, 8'hA5, gw, rw, rd, orv);
        chk("single_wr_gnt", 32'(gw), 32'd1);
        @(negedge clk);
        chk("single_one_pulse", 32'(gnt0), 32'd0);
        do_access(0, 1'b0, 8'h10, 8'h00, gw, rw, rd, orv);
        chk("single_rd_lat", 32'(rw), 32'd2);
        chk("single_rdata", 32'(rd), 32'hA5);
        chk("single_no_rvalid1", 32'(orv), 32'd0);
        idle(2);

        // Seed data for contention
        do_access(0, 1'b1, 8'h01, 8'h11, gw, rw, rd, orv);
        do_access(1, 1'b1, 8'h02, 8'h22, gw, rw, rd, orv);
        idle(2);

        // Lone continuous requester 1
        req1 = 1; we1 = 0; addr1 = 8'h03; wdata1 = '0;
        pulses = 0; consec = 0; prev = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gnt1) pulses++;
            if (gnt1 && prev) consec++;
            prev = gnt1;
        end
        req1 = 0;
        chk("lone_pulses", 32'(pulses), 32'd5);
        chk("lone_consec", 32'(consec), 32'd0);
        idle(4);

        // Contention: both hold reads, grants alternate starting with 0
        req0 = 1; we0 = 0; addr0 = 8'h01;
        req1 = 1; we1 = 0; addr1 = 8'h02;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("cont_gnt0", 32'(gnt0), 32'(i % 2));
            chk("cont_gnt1", 32'(gnt1), 32'((i + 1) % 2));
        end
        req0 = 0; req1 = 0;
        idle(4);
        chk("cont_rdata0", 32'(rdata0), 32'h11);
        chk("cont_rdata1", 32'(rdata1), 32'h22);

        // Random traffic on a small address window
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (req0 && gnt0) req0 = 0;
            if (req1 && gnt1) req1 = 0;
            if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1; we0 = 1'($urandom_range(0, 1));
                addr0 = AW'($urandom_range(0, 15)); wdata0 = DW'($urandom);
            end
            if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1; we1 = 1'($urandom_range(0, 1));
                addr1 = AW'($urandom_range(0, 15)); wdata1 = DW'($urandom);
            end
        end
        for (int c = 0; c < 50 && (req0 || req1); c++) begin
            @(negedge clk);
            if (req0 && gnt0) req0 = 0;
            if (req1 && gnt1) req1 = 0;
        end
        chk("drain_done", 32'({req0, req1}), 32'd0);
        idle(5);

        // Reset one cycle after a read grant: in-flight read discarded
        req0 = 1; we0 = 0; addr0 = 8'h10;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt0) begin n = 1; break; end
        end
        req0 = 0;
        chk("midrd_gnt", 32'(n), 32'd1);
        @(negedge clk);
        rst_n = 0;
        #1;
        check_all_zero("midrd_reset");
        idle(2);
        rst_n = 1;
        rvcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
`ifdef RAM_ARB_CLEAR_EN
            if (i == 0) begin
                chk("restart_busy", 32'(busy), 32'd1);
                chk("restart_addr", 32'(ram_addr), 32'd0);
            end
`endif
            if (rvalid0) rvcount++;
        end
        chk("midrd_no_rvalid", 32'(rvcount), 32'd0);
`ifdef RAM_ARB_CLEAR_EN
        for (int i = 0; i < 400 && busy; i++) @(negedge clk);
`endif
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester round-robin arbiter and sequencer for the single-port 256 x 8 `ram` block. It serialises read and write requests from two independent masters onto the one RAM port and returns read data to the requester that issued the read. When built with the clear option, it zero-fills the whole RAM after reset before accepting any traffic. It sits directly between the masters and the `ram` instance, and owns that instance's `wr_en`, `addr` and `din` inputs.

## Interface
Parameters:
- `AW`, default 8: address width; RAM depth is 2^AW.
- `DW`, default 8: data width.

Ports:
- `sys_clk`  in  1  system clock, rising-edge.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `req0` / `req1`  in  1  access request; held high until the matching `gnt` is seen.
- `we0` / `we1`  in  1  1 = write, 0 = read; must be stable while `req` is high.
- `addr0` / `addr1`  in  AW  access address; must be stable while `req` is high.
- `wdata0` / `wdata1`  in  DW  write data; must be stable while `req` is high.
- `gnt0` / `gnt1`  out  1  one-cycle pulse: the access has been issued to the RAM.
- `rvalid0` / `rvalid1`  out  1  one-cycle pulse: `rdata` holds read data for this requester.
- `rdata0` / `rdata1`  out  DW  registered read data; holds its value between `rvalid` pulses.
- `busy`  out  1  high while the clear sequence runs.
- `ram_wr_en`  out  1  to `ram.wr_en`.
- `ram_addr`  out  AW  to `ram.addr`.
- `ram_din`  out  DW  to `ram.din`; 0 whenever `ram_wr_en` is 0.
- `ram_dout`  in  DW  from `ram.dout`; the RAM has a registered read with 1-cycle latency.

## Operation
- The FSM has two states: CLEAR and ARB. After reset it enters CLEAR when the clear option is built in, and ARB otherwise.
- CLEAR:
  - An AW-bit counter steps from 0 to 2^AW-1, one address per cycle, driving `ram_wr_en`=1, `ram_addr`=counter, `ram_din`=0.
  - `busy`=1 throughout CLEAR and no grants are issued.
  - After address 2^AW-1 is issued, the FSM moves to ARB.
  - Requests held during CLEAR are not dropped; they are serviced in ARB.
- ARB: at each edge, every `req_i` is sampled and masked by `gnt_i`.
  - The mask stops a requester from being re-granted on the edge right after its own grant.
  - If one masked request is present, it wins.
  - If both are present, the requester that did not win last time wins (round-robin).
  - The last-winner pointer resets to 1, so requester 0 wins the first contention.
  - For the winner, the block registers `gnt_i`=1, `ram_addr`=`addr_i`, `ram_wr_en`=`we_i`, and `ram_din`=`wdata_i` (write) or 0 (read).
  - With no winner, the block drives `ram_wr_en`=0, `ram_din`=0, keeps `ram_addr` at its previous value, and drives both `gnt` low.
- Read return: a 2-stage tag pipeline tracks the requester ID of each read.
  - `rdata_i` captures `ram_dout`, and `rvalid_i` pulses, 2 cycles after `gnt_i`.
  - `rdata` of the other requester is unchanged.
- Ordering: accesses reach the RAM in grant order, so a read granted after a write to the same address returns the new data.
- Reset (any time, asynchronous):
  - All outputs go to 0: `gnt*`, `rvalid*`, `rdata*`, `busy`, `ram_*`.
  - The counter is cleared, the pointer is set to 1, and in-flight reads are discarded (no `rvalid`).
  - CLEAR restarts from address 0 when built in.

## Timing
- Request sampled at edge k: `gnt` is high during cycle [k, k+1), and the RAM port is driven over the same interval.
- A write commits at the RAM at edge k+1.
- Read: `rvalid`/`rdata` are valid during [k+2, k+3).
- Throughput:
  - 1 access per cycle total.
  - At most 1 grant per 2 cycles per requester, due to the `gnt` mask.
  - Two continuously requesting masters alternate 0,1,0,1.
- CLEAR lasts exactly 2^AW cycles (256 at default).
  - `busy` goes low in the first ARB cycle.
  - The earliest grant is at the edge that ends the last CLEAR cycle: `gnt` in cycle 2^AW, counting from the first clock edge after reset release as cycle 0.

## Configuration
- Macro: `RAM_ARB_CLEAR_EN`.
- Defined: the CLEAR state, its counter and the `busy` logic are compiled in; post-reset zero-fill runs as described above.
- Undefined: the FSM starts in ARB, `busy` is tied to 0, and RAM contents after reset are whatever the `ram` holds.

## Test plan
- Clear-enabled reset:
  - Release reset: `busy`=1 for 256 cycles, with `ram_wr_en`=1, `ram_addr` 0x00..0xFF in order and `ram_din`=0.
  - Then `busy`=0; requester 0 reads 0x55 and gets `rdata0`=0x00.
- Single requester: requester 0 writes 0xA5 to 0x10, then reads 0x10.
  - Each access produces exactly one `gnt0` pulse.
  - `rvalid0` pulses 2 cycles after the read grant with `rdata0`=0xA5; `rvalid1` stays 0.
- Contention: both requesters hold reads (0x01 and 0x02) continuously.
  - Grants alternate `gnt0`,`gnt1`,... starting with `gnt0`, one per cycle.
  - `rdata0`=mem[0x01] and `rdata1`=mem[0x02].
- Lone continuous requester: `req1` held high with no handshake drop.
  - `gnt1` pulses every other cycle and is never high on two consecutive cycles.
- Same-address race: requester 0 reads 0x20 and requester 1 writes 0x3C to 0x20 in the same cycle, as the first contention after reset.
  - Read is granted first and returns the old value.
  - A repeat read of 0x20 returns 0x3C.
- Reset mid-read: assert `sys_rst_n`=0 one cycle after `gnt0` for a read.
  - All outputs are 0 immediately.
  - No `rvalid0` appears after release; CLEAR restarts at 0x00 when enabled.
